// File: rtl/apb_cmd_master.sv
// APB initiator that turns a valid/ready command stream into single APB transfers
// and returns read data or error/timeout status on a valid/ready response channel.
module apb_cmd_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       timed_out;

    // pready wins over an expiring counter, so timeout only fires with pready low
    assign timed_out = (wait_cnt == 8'(TIMEOUT - 1)) && !pready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs decode straight from state so reset drops them immediately
    assign cmd_ready = (state == IDLE);
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrite      <= 1'b0;
            paddr       <= 32'h0;
            pwdata      <= 32'h0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite   <= cmd_write;
                        paddr    <= cmd_addr;
                        pwdata   <= cmd_wdata;
                        wait_cnt <= 8'h0;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata   <= pwrite ? 32'h0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        rsp_rdata   <= 32'h0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master: write, waited read, slave error,
// timeout and its boundary, response backpressure and reset during ACCESS.
module tb_apb_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks;
    int failures;
    int acc_cycles;

    apb_cmd_master #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic drive_slave(input logic rdy, input logic err, input logic [31:0] rdata);
        pready  = rdy;
        pslverr = err;
        prdata  = rdata;
    endtask

    // Presents a command at a negedge, lets it be accepted, and checks the SETUP cycle
    task automatic accept_cmd(input string tag, input logic write,
                              input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, write, addr, wdata);
        checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput({tag, "_setup_psel"}, 32'(psel), 32'h1);
        checkOutput({tag, "_setup_penable"}, 32'(penable), 32'h0);
        checkOutput({tag, "_setup_paddr"}, paddr, addr);
        checkOutput({tag, "_setup_pwrite"}, 32'(pwrite), 32'(write));
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_valid_clr"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        drive_slave(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        checkOutput("rst_psel", 32'(psel), 32'h0);
        checkOutput("rst_penable", 32'(penable), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_paddr", paddr, 32'h0);
        checkOutput("rst_pwdata", pwdata, 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // Write, zero wait states: RESP two cycles after SETUP
        drive_slave(1'b1, 1'b0, 32'hdead_beef);
        accept_cmd("wr", 1'b1, 32'h4000_a004, 32'h0000_00a5);
        checkOutput("wr_setup_pwdata", pwdata, 32'h0000_00a5);
        @(negedge clk);
        checkOutput("wr_access_psel", 32'(psel), 32'h1);
        checkOutput("wr_access_penable", 32'(penable), 32'h1);
        checkOutput("wr_access_paddr", paddr, 32'h4000_a004);
        checkOutput("wr_access_pwdata", pwdata, 32'h0000_00a5);
        checkOutput("wr_access_cmd_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("wr_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("wr_rsp_psel", 32'(psel), 32'h0);
        release_rsp("wr");
        checkOutput("wr_paddr_held", paddr, 32'h4000_a004);

        // Read with 3 wait states; pslverr during waits must be ignored
        drive_slave(1'b0, 1'b1, 32'h5555_5555);
        accept_cmd("rd", 1'b0, 32'h4000_a028, 32'h0);
        acc_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (penable) acc_cycles++;
            checkOutput("rd_wait_paddr", paddr, 32'h4000_a028);
            if (i == 3) drive_slave(1'b1, 1'b0, 32'h0000_1234);
        end
        @(negedge clk);
        checkOutput("rd_penable_cycles", 32'(acc_cycles), 32'd4);
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
        checkOutput("rd_rsp_err", 32'(rsp_err), 32'h0);
        release_rsp("rd");

        // Slave error on completion, then hold the response for 5 cycles
        drive_slave(1'b1, 1'b1, 32'h0);
        accept_cmd("se", 1'b1, 32'h4000_a030, 32'h0000_0077);
        @(negedge clk);
        @(negedge clk);
        drive_slave(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h4000_0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp_rsp_err", 32'(rsp_err), 32'h1);
            checkOutput("bp_rsp_timeout", 32'(rsp_timeout), 32'h0);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            checkOutput("bp_psel", 32'(psel), 32'h0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        release_rsp("se");

        // Timeout: pready held low, bounded count of ACCESS cycles
        drive_slave(1'b0, 1'b0, 32'hffff_ffff);
        accept_cmd("to", 1'b0, 32'h4000_a040, 32'h0);
        acc_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!penable) break;
            acc_cycles++;
        end
        checkOutput("to_access_cycles", 32'(acc_cycles), 32'd16);
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("to_rsp_err", 32'(rsp_err), 32'h1);
        checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
        checkOutput("to_rsp_rdata", rsp_rdata, 32'h0);
        release_rsp("to");

        // pready arriving on the 16th ACCESS cycle completes normally
        drive_slave(1'b0, 1'b0, 32'h0);
        accept_cmd("tb", 1'b0, 32'h4000_a044, 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) drive_slave(1'b1, 1'b0, 32'h0000_beef);
        end
        @(negedge clk);
        checkOutput("tb_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("tb_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("tb_rsp_timeout", 32'(rsp_timeout), 32'h0);
        checkOutput("tb_rsp_rdata", rsp_rdata, 32'h0000_beef);
        release_rsp("tb");

        // Reset pulse in ACCESS abandons the transfer
        drive_slave(1'b0, 1'b0, 32'h0);
        accept_cmd("ra", 1'b1, 32'h4000_a010, 32'h0000_0011);
        @(negedge clk);
        checkOutput("ra_access_penable", 32'(penable), 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("ra_async_psel", 32'(psel), 32'h0);
        checkOutput("ra_async_penable", 32'(penable), 32'h0);
        drive_slave(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("ra_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("ra_paddr_clr", paddr, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ra_rsp_valid_after", 32'(rsp_valid), 32'h0);

        accept_cmd("pr", 1'b1, 32'h4000_a014, 32'h0000_0022);
        @(negedge clk);
        checkOutput("pr_access_penable", 32'(penable), 32'h1);
        @(negedge clk);
        checkOutput("pr_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("pr_rsp_err", 32'(rsp_err), 32'h0);
        release_rsp("pr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles allowed with pready low (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have ports cmd_write (input, 1, 1=write), cmd_addr (input, 32, byte address) and cmd_wdata (input, 32, write data).
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32, read data), rsp_err (output, 1, slave error or timeout) and rsp_timeout (output, 1, timeout occurred).
REQ-008 SHALL have APB initiator ports psel, penable and pwrite (outputs, 1), paddr and pwdata (outputs, 32), prdata (input, 32), pready (input, 1) and pslverr (input, 1).

Function
REQ-009 SHALL implement the states IDLE, SETUP, ACCESS and RESP; there SHALL be no other reachable state.
REQ-010 SHALL drive cmd_ready=1 only in IDLE.
REQ-011 IDLE: on cmd_valid=1, SHALL register cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
REQ-012 SETUP: SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-013 ACCESS: SHALL drive psel=1 and penable=1, and SHALL remain in ACCESS while pready=0 and the timeout has not expired.
REQ-014 SHALL hold paddr, pwrite and pwdata stable from SETUP through the final ACCESS cycle.
REQ-015 SHALL hold paddr, pwrite and pwdata at their last values after the transfer until the next command is accepted.
REQ-016 ACCESS with pready=1, on that edge SHALL: rsp_rdata <= prdata if read, else 32'h0; rsp_err <= pslverr; rsp_timeout <= 0; go to RESP.
REQ-017 SHALL count consecutive ACCESS cycles with pready=0 in an 8-bit counter, cleared on SETUP entry.
REQ-018 When the counter equals TIMEOUT-1 and pready=0, SHALL terminate the transfer: rsp_rdata <= 0, rsp_err <= 1, rsp_timeout <= 1, go to RESP.
REQ-019 Timeout boundary: pready=1 in the same cycle the counter equals TIMEOUT-1 SHALL be a normal completion (pready has priority).
REQ-020 RESP: SHALL drive psel=0, penable=0 and rsp_valid=1, and SHALL hold rsp_rdata, rsp_err and rsp_timeout stable until rsp_ready=1, then go to IDLE.
REQ-021 SHALL drive rsp_valid=0 outside RESP; rsp_* fields SHALL keep their last values.
REQ-022 Minimum latency: command accepted at edge N, SETUP in cycle N+1, ACCESS in N+2; with pready=1 in N+2, rsp_valid=1 in N+3. Back-to-back throughput SHALL be one transfer per 4 cycles (with rsp_ready tied high).
REQ-023 pslverr and prdata SHALL be ignored in every cycle except the completing ACCESS cycle.
REQ-024 penable SHALL never be 1 while psel=0.
REQ-025 SHALL never assert psel for two transfers without an intervening SETUP cycle.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0, and cmd_ready=1 after release.
REQ-027 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abandon the transfer with no response generated.
REQ-028 The first command after reset release SHALL follow REQ-022 timing.

Verification
REQ-029 Write: cmd addr 32'h4000a004, wdata 32'h0000_00a5, pready=1 -> one SETUP cycle then one ACCESS cycle with the address and data stable; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-030 Read with 3 wait states: addr 32'h4000a028; pready low for 3 ACCESS cycles, then prdata=32'h0000_1234 with pready=1 -> rsp_rdata=32'h1234, rsp_err=0, penable high for 4 cycles.
REQ-031 Slave error: pslverr=1 on the completing cycle -> rsp_err=1, rsp_timeout=0; pslverr=1 during wait cycles alone -> ignored.
REQ-032 Timeout: pready held 0 with TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 on the 16th cycle -> normal completion.
REQ-033 Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_* held stable, cmd_ready=0, psel=0 throughout.
REQ-034 Reset in ACCESS: rst pulse -> psel and penable fall in the same cycle, no rsp_valid, next command completes normally.
